// File: rtl/pet_video_capture.sv
// PET video sink: packs serial pixels into bytes for a req/ack write port and
// measures active frame geometry, asserting locked once it is stable.
module pet_video_capture #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        pix,
    input  logic        vid_de,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    output logic        wr_req,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic [9:0]  width,
    output logic [8:0]  height,
    output logic        locked,
    output logic        overflow
);
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

    logic       hs_prev, vs_prev;
    logic [7:0] sr;
    logic [2:0] bitcnt;
    logic [9:0] pxcnt;
    logic       active;
    logic [6:0] xbyte;
    logic [8:0] y, lines;
    logic [9:0] line_w;
    logic       uniform;
    logic [3:0] lockcnt;

    logic       hs_rise, vs_rise;
    logic [7:0] sr_n;
    logic [2:0] bitcnt_n;
    logic [9:0] pxcnt_n;
    logic       active_n;
    logic [6:0] xbyte_n;
    logic [8:0] y_n, lines_n;
    logic [9:0] line_w_n;
    logic       uniform_n;
    logic [3:0] lockcnt_n;
    logic [9:0] width_n;
    logic [8:0] height_n;
    logic       consistent;
    logic       byte_vld;
    logic [7:0] byte_data;
    logic [15:0] byte_addr;

    assign hs_rise = vid_hsync & ~hs_prev;
    assign vs_rise = vid_vsync & ~vs_prev;

    // Next state of one ce_pix event, applied in order: pixel, line end, frame end.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sr_n       = sr;
        bitcnt_n   = bitcnt;
        pxcnt_n    = pxcnt;
        active_n   = active;
        xbyte_n    = xbyte;
        y_n        = y;
        lines_n    = lines;
        line_w_n   = line_w;
        uniform_n  = uniform;
        lockcnt_n  = lockcnt;
        width_n    = width;
        height_n   = height;
        consistent = 1'b0;
        byte_vld   = 1'b0;
        byte_data  = '0;
        byte_addr  = '0;

        if (vid_de) begin
            sr_n     = {sr[6:0], pix};
            pxcnt_n  = (pxcnt == 10'd1023) ? pxcnt : pxcnt + 10'd1;
            active_n = 1'b1;
            if (bitcnt == 3'd7) begin
                byte_vld  = (xbyte != 7'd127);
                byte_data = sr_n;
                byte_addr = {y, xbyte};
                bitcnt_n  = 3'd0;
                xbyte_n   = (xbyte == 7'd127) ? xbyte : xbyte + 7'd1;
            end else begin
                bitcnt_n = bitcnt + 3'd1;
            end
        end

        if (hs_rise) begin
            // Partial byte at line end is left-justified, zero padded.
            if (bitcnt_n != 3'd0) begin
                byte_vld  = (xbyte_n != 7'd127);
                byte_data = sr_n << (4'd8 - {1'b0, bitcnt_n});
                byte_addr = {y, xbyte_n};
            end
            if (active_n) begin
                if (lines == 9'd0) begin
                    line_w_n = pxcnt_n;
                end else if (pxcnt_n != line_w) begin
                    uniform_n = 1'b0;
                end
                y_n     = (y == 9'd511) ? y : y + 9'd1;
                lines_n = (lines == 9'd511) ? lines : lines + 9'd1;
            end
            bitcnt_n = 3'd0;
            pxcnt_n  = '0;
            active_n = 1'b0;
            xbyte_n  = '0;
        end

        if (vs_rise) begin
            consistent = uniform_n && (lines_n != 9'd0) &&
                         (line_w_n == width) && (lines_n == height);
            if (!consistent) begin
                lockcnt_n = '0;
            end else if (lockcnt != LOCK_MAX) begin
                lockcnt_n = lockcnt + 4'd1;
            end
            width_n   = line_w_n;
            height_n  = lines_n;
            y_n       = '0;
            lines_n   = '0;
            uniform_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            sr       <= '0;
            bitcnt   <= '0;
            pxcnt    <= '0;
            active   <= 1'b0;
            xbyte    <= '0;
            y        <= '0;
            lines    <= '0;
            line_w   <= '0;
            uniform  <= 1'b1;
            lockcnt  <= '0;
            width    <= '0;
            height   <= '0;
            locked   <= 1'b0;
            wr_req   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_req && wr_ack) begin
                wr_req <= 1'b0;
            end
            if (ce_pix) begin
                hs_prev <= vid_hsync;
                vs_prev <= vid_vsync;
                sr      <= sr_n;
                bitcnt  <= bitcnt_n;
                pxcnt   <= pxcnt_n;
                active  <= active_n;
                xbyte   <= xbyte_n;
                y       <= y_n;
                lines   <= lines_n;
                line_w  <= line_w_n;
                uniform <= uniform_n;
                lockcnt <= lockcnt_n;
                width   <= width_n;
                height  <= height_n;
                locked  <= (lockcnt_n == LOCK_MAX);
                // A held byte that is not being acked wins; the newcomer is lost.
                if (byte_vld) begin
                    if (wr_req && !wr_ack) begin
                        overflow <= 1'b1;
                    end else begin
                        wr_req  <= 1'b1;
                        wr_addr <= byte_addr;
                        wr_data <= byte_data;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pet_video_capture.sv
// Self-checking bench for pet_video_capture: random and directed frames are
// compared against a line/frame level model of the expected writes and geometry.
module tb_pet_video_capture;
    localparam int LOCK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic        pix = 1'b0;
    logic        vid_de = 1'b0;
    logic        vid_hsync = 1'b0;
    logic        vid_vsync = 1'b0;
    logic        wr_ack = 1'b1;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [9:0]  width;
    logic [8:0]  height;
    logic        locked;
    logic        overflow;

    pet_video_capture #(.LOCK_FRAMES(LOCK_FRAMES)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .pix(pix), .vid_de(vid_de),
        .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .width(width),
        .height(height), .locked(locked), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [23:0] exp_q[$];
    int  m_width = 0, m_height = 0, m_lockcnt = 0;
    bit  m_overflow = 1'b0;
    int  fr_y = 0, fr_lines = 0, fr_linew = 0;
    bit  fr_uniform = 1'b1;
    bit  px[0:1023];

    // Directed-test knobs
    int ce_gap = 0;
    int ack_hold = 0;
    int drop_idx = -1;
    int gap_chk_at = -1;
    int hold_chk_at = -1;
    logic [7:0] probe_data;

    int wr_count = 0;
    int first_addr = 0, last_addr = 0;

    function automatic logic [7:0] pack(input int start, input int n);
        logic [7:0] d;
        d = '0;
        for (int b = 0; b < 8; b++)
            if (start + b < n) d[7-b] = px[start+b];
        return d;
    endfunction

    function automatic bit a5bit(input int i);
        logic [7:0] v;
        v = 8'hA5;
        return v[7 - (i % 8)];
    endfunction

    function automatic void model_line(input int n);
        if (n > 0) begin
            for (int k = 0; k * 8 < n; k++) begin
                logic [15:0] a;
                a = 16'(fr_y * 128 + k);
                if (k < 127 && k != drop_idx) exp_q.push_back({a, pack(k * 8, n)});
            end
            if (fr_lines == 0) fr_linew = n;
            else if (n != fr_linew) fr_uniform = 1'b0;
            if (fr_y < 511) fr_y++;
            if (fr_lines < 511) fr_lines++;
        end
    endfunction

    function automatic void model_frame_end();
        bit cons;
        cons = fr_uniform && fr_lines != 0 && fr_linew == m_width && fr_lines == m_height;
        if (!cons) m_lockcnt = 0;
        else if (m_lockcnt < LOCK_FRAMES) m_lockcnt++;
        m_width    = fr_linew;
        m_height   = fr_lines;
        fr_y       = 0;
        fr_lines   = 0;
        fr_uniform = 1'b1;
    endfunction

    function automatic void model_reset();
        m_width = 0; m_height = 0; m_lockcnt = 0; m_overflow = 1'b0;
        fr_y = 0; fr_lines = 0; fr_linew = 0; fr_uniform = 1'b1;
        exp_q.delete();
    endfunction

    // Write monitor: one accepted transfer per clk with req and ack both high.
    always @(negedge clk) begin
        if (!reset && wr_req && wr_ack) begin
            check("wr_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
            if (wr_count == 0) first_addr = int'(wr_addr);
            last_addr = int'(wr_addr);
            wr_count++;
        end
    end

    task automatic tick(input bit ce, input bit de, input bit p, input bit hs, input bit vs,
                        input bit ack);
        ce_pix = ce; vid_de = de; pix = p; vid_hsync = hs; vid_vsync = vs; wr_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic pix_tick(input bit de, input bit p, input bit hs, input bit vs, input bit ack);
        tick(1'b1, de, p, hs, vs, ack);
        repeat (ce_gap) tick(1'b0, de, p, hs, vs, ack);
    endtask

    task automatic do_line(input int n);
        model_line(n);
        for (int i = 0; i < n; i++) begin
            pix_tick(1'b1, px[i], 1'b0, 1'b0, i >= ack_hold);
            if (i == gap_chk_at) begin
                check("no_gap_req", wr_req, 1);
                check("no_gap_data", wr_data, probe_data);
            end
            if (i == hold_chk_at) begin
                check("held_req", wr_req, 1);
                check("held_data", wr_data, probe_data);
            end
        end
        pix_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_vsync();
        pix_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pix_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_frame_end();
    endtask

    task automatic check_frame();
        check("width", width, m_width);
        check("height", height, m_height);
        check("locked", locked, m_lockcnt == LOCK_FRAMES);
        check("overflow", overflow, m_overflow);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_frame(input int w, input int h, input int odd_line, input int odd_w,
                             input bit a5, input bit vs);
        for (int l = 0; l < h; l++) begin
            int n;
            n = (l == odd_line) ? odd_w : w;
            for (int i = 0; i < n; i++) px[i] = a5 ? a5bit(i) : 1'($urandom_range(0, 1));
            do_line(n);
        end
        if (vs) begin
            do_vsync();
            check_frame();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_req"}, wr_req, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_width"}, width, 0);
        check({tag, "_height"}, height, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_all_zero("reset");

        // Full PET frame, every byte 0xA5
        wr_count = 0;
        run_frame(320, 200, -1, 0, 1'b1, 1'b1);
        check("a5_write_count", wr_count, 8000);
        check("a5_first_addr", first_addr, 0);
        check("a5_last_addr", last_addr, 25511);
        check("a5_width", width, 320);
        check("a5_height", height, 200);

        // 13 all-ones pixels, ce_pix every 8th clk
        ce_gap = 7;
        wr_count = 0;
        for (int i = 0; i < 13; i++) px[i] = 1'b1;
        do_line(13);
        do_vsync();
        check_frame();
        check("partial_writes", wr_count, 2);
        check("partial_width", width, 13);
        ce_gap = 0;

        // Ack arrives on the same clk the second byte completes
        for (int i = 0; i < 24; i++) px[i] = 1'($urandom_range(0, 1));
        probe_data = pack(8, 24);
        ack_hold = 15;
        gap_chk_at = 15;
        do_line(24);
        ack_hold = 0;
        gap_chk_at = -1;
        do_vsync();
        check_frame();
        check("simul_overflow", overflow, 0);

        // Backpressure: ack low for 20 clks, second byte is lost
        for (int i = 0; i < 40; i++) px[i] = 1'($urandom_range(0, 1));
        probe_data = pack(0, 40);
        ack_hold = 20;
        hold_chk_at = 19;
        drop_idx = 1;
        m_overflow = 1'b1;
        wr_count = 0;
        do_line(40);
        ack_hold = 0;
        hold_chk_at = -1;
        drop_idx = -1;
        do_vsync();
        check_frame();
        check("bp_writes", wr_count, 4);
        check("bp_overflow", overflow, 1);

        // Lock acquisition, geometry change, re-acquisition
        ce_gap = 1;
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        ce_gap = 0;
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        check("lock_acquired", locked, 1);
        run_frame(320, 3, 1, 312, 1'b0, 1'b1);
        check("lock_lost", locked, 0);
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        check("lock_reacquired", locked, 1);

        // Asynchronous reset mid-frame, away from any clk edge
        run_frame(320, 2, -1, 0, 1'b0, 1'b0);
        check("pre_reset_drained", exp_q.size(), 0);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        run_frame(320, 2, -1, 0, 1'b0, 1'b1);
        check("post_rst_partial_locked", locked, 0);
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        check("post_rst_f1_locked", locked, 0);
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        check("post_rst_f2_locked", locked, 0);
        run_frame(320, 3, -1, 0, 1'b0, 1'b1);
        check("post_rst_f3_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pet_video_capture.md
# pet_video_capture

Sink for the PET video generator's CRTC-compatible output stream (`pix`, `vid_de`, `vid_hsync`, `vid_vsync`). It packs serial pixels into bytes and writes them out through a req/ack write port, one address per byte, for a framebuffer or scaler. It also measures the active width and height of each frame and reports lock once the frame geometry is stable. It sits downstream of the video/CRTC multiplexer, on the same 8 MHz pixel-enable domain.

## Interface
Parameters:
- `LOCK_FRAMES`, default 2: number of consecutive consistent frames required before `locked` asserts (range 1..15).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce_pix`  in  1  pixel strobe, one `clk` wide (the 8 MHz negative-edge enable). All video inputs are sampled only when `ce_pix`=1.
- `pix`  in  1  pixel value.
- `vid_de`  in  1  display enable.
- `vid_hsync`  in  1  horizontal sync, active high.
- `vid_vsync`  in  1  vertical sync, active high.
- `wr_req`  out  1  a byte is pending on `wr_addr` / `wr_data`.
- `wr_addr`  out  16  {y[8:0], xbyte[6:0]}.
- `wr_data`  out  8  packed pixels; MSB = leftmost pixel.
- `wr_ack`  in  1  sink accepts the pending byte this clk.
- `width`  out  10  active pixels per line in the last completed frame.
- `height`  out  9  active lines in the last completed frame.
- `locked`  out  1  geometry stable.
- `overflow`  out  1  sticky: a byte was dropped.

## Operation
- Edge detection: `hs_prev` and `vs_prev` update only on `ce_pix`. A rising edge is (input & ~prev) on a `ce_pix` clk.
- Pixel packing: on `ce_pix` with `vid_de`=1:
  - sr <= {sr[6:0], pix}; bitcnt++; pxcnt++ (saturates at 1023); the line is marked active.
  - When bitcnt reaches 8, the byte completes, bitcnt returns to 0, and xbyte increments (saturates at 127). Bytes completing with xbyte already at 127 are discarded silently.
- Line end (hsync rise):
  - If bitcnt≠0, flush: emit {sr, zeros} left-justified to 8 bits.
  - If the line was active:
    - on the first active line of the frame, record line_w = pxcnt; on later lines, if pxcnt ≠ line_w, clear the frame's uniform flag;
    - increment y (saturates at 511) and lines.
  - Clear xbyte, bitcnt, pxcnt and the active flag.
- Frame end (vsync rise):
  - width <= line_w; height <= lines.
  - The frame is consistent when it is uniform, lines≠0, and {line_w, lines} equals the previous frame's {width, height}.
  - Consistent: lockcnt++ (saturates at LOCK_FRAMES). Not consistent: lockcnt <= 0.
  - locked = (lockcnt == LOCK_FRAMES).
  - Then y <= 0, lines <= 0, uniform <= 1.
- Event order within one `ce_pix`: the DE pixel first, then line end, then frame end.
- Write port:
  - A completed or flushed byte loads `wr_data`/`wr_addr` and sets `wr_req`.
  - `wr_req` clears on the clk after `wr_ack`=1 is sampled while `wr_req`=1.
  - If a new byte completes while `wr_req`=1 and `wr_ack`=0: the new byte is dropped, the held byte is unchanged, and `overflow` <= 1.
  - If a new byte completes in the same clk as a valid ack: the new byte loads and `wr_req` stays 1.
  - `wr_addr` and `wr_data` are stable while `wr_req`=1.

## Timing
- Reset values: all outputs 0, and all internal state 0 except uniform=1. `overflow` clears only on reset.
- Byte latency: the 8th pixel sampled on `ce_pix` at clk N gives `wr_req`=1 with the byte at clk N+1. A flush byte appears at N+1 after the hsync-rise clk.
- `width`, `height` and `locked` update at N+1 after the vsync-rise clk.
- No combinational path from inputs to outputs.
- Reset asserted mid-line or mid-frame: everything clears immediately. After release, the first frame is only partially captured and cannot count as consistent, because lockcnt restarts from 0.

## Test plan
- Reset: assert `reset` asynchronously (no `clk` edge) mid-frame → all outputs 0 at once. `locked`=0 after release until LOCK_FRAMES+1 full frames have been seen.
- PET frame, 320×200, every byte 0xA5, `wr_ack`=1, `ce_pix` every 8th clk, 512×260 pixel periods per frame:
  - 8000 writes per frame; first write addr 0x0000, last addr 199·128+39 = 25511;
  - `width`=320, `height`=200 after frame 1; `locked`=1 after frame 3 (LOCK_FRAMES=2).
- Partial byte: a 13-pixel all-ones active line → two writes, 0xFF at xbyte 0 and 0xF8 at xbyte 1; `width`=13.
- Backpressure: `ce_pix` every clk, `wr_ack`=0 for 20 clks:
  - first byte held on `wr_data`, second byte dropped, `overflow`=1;
  - release `wr_ack` → exactly one write, then writes resume normally.
- Simultaneous ack and complete: a byte completes in the same clk as `wr_ack` → the next byte is present with no gap and `overflow` stays 0.
- Geometry change: after lock, one line of a frame is 312 pixels wide → `locked` drops at that frame's vsync. The following two good frames of that same geometry re-acquire lock.
